// File: rtl/lii_pkg.sv
// Shared LII link definitions: ID width and packing-ratio helpers used by
// every packer/unpacker that talks to a phy channel.
package lii_pkg;

    localparam int LII_ID_W = 8;

    // Number of kernel beats that make up one phy word.
    function automatic int lii_ratio(input int pw, input int dw);
        return (dw > 0) ? pw / dw : 0;
    endfunction

    // A legal pairing packs a whole number (at least one) of beats per word.
    function automatic bit lii_ratio_ok(input int pw, input int dw);
        return (dw > 0) && (pw >= dw) && ((pw % dw) == 0);
    endfunction

endpackage

// File: rtl/lii_out_slice.sv
// Single-entry output register with valid/ready. Data only changes when the
// slot is empty or being drained, so it holds stable under backpressure.
module lii_out_slice #(
    parameter int W = 128
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    logic [W-1:0] data_q;
    logic         valid_q;

    assign in_ready  = ~valid_q | out_ready;
    assign out_data  = data_q;
    assign out_valid = valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (in_valid && in_ready) begin
            // A load while full implies the old word drains this cycle.
            data_q  <= in_data;
            valid_q <= 1'b1;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/lii_tx_packer.sv
// Transmit-side LII packer: gathers PW/DW kernel beats into one phy word,
// lane 0 in the LSBs, with early close of a partial word on s_tlast.
module lii_tx_packer
    import lii_pkg::*;
#(
    parameter int                    DW     = 64,
    parameter int                    PW     = 128,
    parameter logic [LII_ID_W-1:0]   SRC_ID = 8'h00,
    parameter logic [LII_ID_W-1:0]   DST_ID = 8'h00
) (
    input  logic                 aclk,
    input  logic                 arstn,
    input  logic [DW-1:0]        s_tdata,
    input  logic                 s_tvalid,
    output logic                 s_tready,
    input  logic                 s_tlast,
    output logic [PW-1:0]        lii_out_p0_tdata,
    output logic                 lii_out_p0_tvalid,
    input  logic                 lii_out_p0_tready,
    output logic [LII_ID_W-1:0]  lii_out_p0_src,
    output logic [LII_ID_W-1:0]  lii_out_p0_dst,
    output logic [31:0]          words_sent,
    output logic [15:0]          partial_flushes
);

    localparam int R  = lii_ratio(PW, DW);
    localparam int LW = (R > 1) ? $clog2(R) : 1;
    localparam logic [LW-1:0] LAST_LANE = LW'(R - 1);

    if (!lii_ratio_ok(PW, DW)) begin : g_bad_ratio
        $error("lii_tx_packer: PW must be a non-zero multiple of DW");
    end

    logic [LW-1:0] lane;
    logic          at_last;
    logic          closing;
    logic          beat_acc;
    logic          word_done;
    logic          early_close;
    logic          slice_ready;
    logic [PW-1:0] word;

    assign lii_out_p0_src = SRC_ID;
    assign lii_out_p0_dst = DST_ID;

    // Only a beat that closes a word needs room in the output register.
    assign at_last     = (lane == LAST_LANE);
    assign closing     = at_last | s_tlast;
    assign s_tready    = ~closing | slice_ready;
    assign beat_acc    = s_tvalid & s_tready;
    assign word_done   = beat_acc & closing;
    assign early_close = word_done & s_tlast & ~at_last;

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn)
            lane <= '0;
        else if (beat_acc)
            lane <= closing ? '0 : lane + 1'b1;
    end

    if (R > 1) begin : g_pack
        logic [(R-1)*DW-1:0] acc;

        always_ff @(posedge aclk or negedge arstn) begin
            if (!arstn) begin
                acc <= '0;
            end else if (beat_acc) begin
                if (closing) begin
                    acc <= '0;
                end else begin
                    for (int k = 0; k < R - 1; k++)
                        if (lane == LW'(k))
                            acc[k*DW +: DW] <= s_tdata;
                end
            end
        end

        // Lanes below the current one come from the accumulator, the live
        // beat sits at `lane`, everything above stays zero.
        always_comb begin
            word = '0;
            for (int k = 0; k < R - 1; k++)
                if (LW'(k) < lane)
                    word[k*DW +: DW] = acc[k*DW +: DW];
            for (int k = 0; k < R; k++)
                if (lane == LW'(k))
                    word[k*DW +: DW] = s_tdata;
        end
    end else begin : g_pass
        assign word = s_tdata;
    end

    lii_out_slice #(
        .W (PW)
    ) u_slice (
        .clk       (aclk),
        .rst_n     (arstn),
        .in_data   (word),
        .in_valid  (word_done),
        .in_ready  (slice_ready),
        .out_data  (lii_out_p0_tdata),
        .out_valid (lii_out_p0_tvalid),
        .out_ready (lii_out_p0_tready)
    );

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            words_sent      <= '0;
            partial_flushes <= '0;
        end else begin
            if (lii_out_p0_tvalid && lii_out_p0_tready)
                words_sent <= words_sent + 32'd1;
            if (early_close && partial_flushes != 16'hFFFF)
                partial_flushes <= partial_flushes + 16'd1;
        end
    end

endmodule

// File: tb/tb_lii_tx_packer.sv
// Bench for lii_tx_packer: a queue-based word model checked every cycle on
// two instances (R=2 and R=1), plus literal checks on directed vectors.
module tb_lii_tx_packer;

    localparam int RA = 2;

    logic          aclk;
    logic          arstn;

    logic [63:0]   s_tdata;
    logic          s_tvalid, s_tready, s_tlast;
    logic [127:0]  o_tdata;
    logic          o_tvalid, o_tready;
    logic [7:0]    o_src, o_dst;
    logic [31:0]   ws;
    logic [15:0]   pf;

    logic [63:0]   b_tdata;
    logic          b_tvalid, b_tready, b_tlast;
    logic [63:0]   b_o_tdata;
    logic          b_o_tvalid, b_o_tready;
    logic [7:0]    b_src, b_dst;
    logic [31:0]   b_ws;
    logic [15:0]   b_pf;

    int n_pass = 0;
    int n_total = 0;

    lii_tx_packer #(.DW(64), .PW(128), .SRC_ID(8'h03), .DST_ID(8'h07)) dut (
        .aclk(aclk), .arstn(arstn),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
        .lii_out_p0_tdata(o_tdata), .lii_out_p0_tvalid(o_tvalid), .lii_out_p0_tready(o_tready),
        .lii_out_p0_src(o_src), .lii_out_p0_dst(o_dst),
        .words_sent(ws), .partial_flushes(pf)
    );

    lii_tx_packer #(.DW(64), .PW(64), .SRC_ID(8'h11), .DST_ID(8'h22)) dut1 (
        .aclk(aclk), .arstn(arstn),
        .s_tdata(b_tdata), .s_tvalid(b_tvalid), .s_tready(b_tready), .s_tlast(b_tlast),
        .lii_out_p0_tdata(b_o_tdata), .lii_out_p0_tvalid(b_o_tvalid), .lii_out_p0_tready(b_o_tready),
        .lii_out_p0_src(b_src), .lii_out_p0_dst(b_dst),
        .words_sent(b_ws), .partial_flushes(b_pf)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", name, got, exp);
    endtask

    // ---------------- model of the R=2 instance ----------------
    logic [63:0]  mq[$];
    logic         m_ov;
    logic [127:0] m_od;
    logic [31:0]  m_ws;
    logic [15:0]  m_pf;
    bit           ma_rdy, ma_close;
    logic [127:0] ma_w;

    function automatic bit pred_a();
        return !((mq.size() == RA - 1) || s_tlast) || !m_ov || o_tready;
    endfunction

    always @(posedge aclk or negedge arstn) begin : model_a
        if (!arstn) begin
            mq.delete(); m_ov = 1'b0; m_od = '0; m_ws = '0; m_pf = '0;
        end else begin
            ma_rdy = pred_a();
            ma_close = (mq.size() == RA - 1) || s_tlast;
            if (m_ov && o_tready) begin
                m_ws = m_ws + 32'd1;
                m_ov = 1'b0;
            end
            if (s_tvalid && ma_rdy) begin
                if (ma_close) begin
                    ma_w = '0;
                    for (int i = 0; i < mq.size(); i++) ma_w[i*64 +: 64] = mq[i];
                    ma_w[mq.size()*64 +: 64] = s_tdata;
                    if (s_tlast && mq.size() < RA - 1 && m_pf != 16'hFFFF) m_pf = m_pf + 16'd1;
                    mq.delete();
                    m_od = ma_w;
                    m_ov = 1'b1;
                end else begin
                    mq.push_back(s_tdata);
                end
            end
        end
    end

    // ---------------- model of the R=1 instance ----------------
    logic         m1_ov;
    logic [63:0]  m1_od;
    logic [31:0]  m1_ws;
    bit           mb_rdy;

    always @(posedge aclk or negedge arstn) begin : model_b
        if (!arstn) begin
            m1_ov = 1'b0; m1_od = '0; m1_ws = '0;
        end else begin
            mb_rdy = !m1_ov || b_o_tready;
            if (m1_ov && b_o_tready) begin
                m1_ws = m1_ws + 32'd1;
                m1_ov = 1'b0;
            end
            if (b_tvalid && mb_rdy) begin
                m1_od = b_tdata;
                m1_ov = 1'b1;
            end
        end
    end

    always @(negedge aclk) begin : compare
        chk("a_tready", s_tready, pred_a());
        chk("a_tvalid", o_tvalid, m_ov);
        chk("a_tdata",  o_tdata,  m_od);
        chk("a_words",  ws,       m_ws);
        chk("a_pflush", pf,       m_pf);
        chk("b_tready", b_tready, !m1_ov || b_o_tready);
        chk("b_tvalid", b_o_tvalid, m1_ov);
        chk("b_tdata",  b_o_tdata,  m1_od);
        chk("b_words",  b_ws,       m1_ws);
        chk("b_pflush", b_pf,       16'h0);
    end

    // Drive one beat and hold it until accepted (bounded).
    task automatic send_a(input logic [63:0] d, input logic l);
        bit ok;
        s_tdata = d; s_tvalid = 1'b1; s_tlast = l;
        for (int i = 0; i < 50; i++) begin
            @(negedge aclk); ok = s_tready;
            @(posedge aclk); #1;
            if (ok) return;
        end
        n_total++;
        $display("FAIL a_send_timeout data=%h never accepted", d);
    endtask

    task automatic send_b(input logic [63:0] d, input logic l);
        bit ok;
        b_tdata = d; b_tvalid = 1'b1; b_tlast = l;
        for (int i = 0; i < 50; i++) begin
            @(negedge aclk); ok = b_tready;
            @(posedge aclk); #1;
            if (ok) return;
        end
        n_total++;
        $display("FAIL b_send_timeout data=%h never accepted", d);
    endtask

    task automatic idle_a();
        s_tvalid = 1'b0; s_tlast = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        time t0;
        logic [31:0] base;
        arstn = 1'b0;
        s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; o_tready = 1'b1;
        b_tdata = '0; b_tvalid = 1'b0; b_tlast = 1'b0; b_o_tready = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_tvalid", o_tvalid, 1'b0);
        chk("rst_tdata",  o_tdata,  128'h0);
        chk("rst_src",    o_src,    8'h03);
        chk("rst_dst",    o_dst,    8'h07);
        chk("rst_words",  ws,       32'h0);
        @(negedge aclk) arstn = 1'b1;
        @(posedge aclk); #1;

        // Two beats form one word, visible right after the second is taken.
        send_a(64'hA, 1'b0);
        send_a(64'hB, 1'b0);
        idle_a();
        chk("w1_tvalid", o_tvalid, 1'b1);
        chk("w1_tdata",  o_tdata,  {64'hB, 64'hA});
        @(posedge aclk); #1;
        chk("w1_words",  ws, 32'd1);

        // Sustained 8 beats: one beat per cycle, four words.
        base = ws;
        t0 = $time;
        for (int i = 0; i < 8; i++) send_a(64'h100 + 64'(i), 1'b0);
        chk("burst_cycles", 128'($time - t0), 128'd80);
        idle_a();
        chk("burst_last", o_tdata, {64'h107, 64'h106});
        @(posedge aclk); #1;
        chk("burst_words", ws, base + 32'd4);

        // Early flush at lane 0.
        send_a(64'h5, 1'b1);
        idle_a();
        chk("flush_tdata", o_tdata, 128'h5);
        @(posedge aclk); #1;
        chk("flush_count", pf, 16'd1);
        send_a(64'h1, 1'b0);
        send_a(64'h2, 1'b0);
        idle_a();
        chk("after_flush", o_tdata, {64'h2, 64'h1});
        @(posedge aclk); #1;

        // Backpressure: first word held, C buffered, D stalled.
        o_tready = 1'b0;
        send_a(64'h10, 1'b0);
        send_a(64'h11, 1'b0);
        send_a(64'hC, 1'b0);
        s_tdata = 64'hD; s_tvalid = 1'b1; s_tlast = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            chk("stall_ready", s_tready, 1'b0);
            chk("stall_hold",  o_tdata,  {64'h11, 64'h10});
        end
        @(posedge aclk); #1;
        o_tready = 1'b1;
        @(posedge aclk); #1;
        idle_a();
        chk("stall_reload", o_tdata, {64'hD, 64'hC});
        chk("stall_valid",  o_tvalid, 1'b1);
        @(posedge aclk); #1;

        // Reset mid-word discards the buffered beat.
        send_a(64'hE0, 1'b0);
        idle_a();
        #2 arstn = 1'b0;
        #1;
        chk("mid_rst_tvalid", o_tvalid, 1'b0);
        chk("mid_rst_words",  ws,       32'h0);
        chk("mid_rst_pflush", pf,       16'h0);
        @(negedge aclk) arstn = 1'b1;
        @(posedge aclk); #1;
        send_a(64'hE, 1'b0);
        send_a(64'hF, 1'b0);
        idle_a();
        chk("post_rst_word", o_tdata, {64'hF, 64'hE});
        @(posedge aclk); #1;

        // R=1: every beat is a word; s_tlast never counts as partial.
        send_b(64'h11, 1'b1);
        chk("r1_w0", b_o_tdata, 64'h11);
        send_b(64'h22, 1'b0);
        chk("r1_w1", b_o_tdata, 64'h22);
        send_b(64'h33, 1'b1);
        chk("r1_w2", b_o_tdata, 64'h33);
        b_tvalid = 1'b0; b_tlast = 1'b0;
        @(posedge aclk); #1;
        chk("r1_words",  b_ws, 32'd3);
        chk("r1_pflush", b_pf, 16'd0);
        chk("r1_src",    b_src, 8'h11);

        repeat (2) @(posedge aclk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/lii_tx_packer.md
Name: lii_tx_packer

Overview:
- Transmit-side packer for the LII physical link. Takes one narrow kernel output stream (DW bits per beat) and gathers R = PW/DW consecutive beats into one PW-bit phy word.
- Each word is tagged with fixed src/dst IDs and driven onto one LII phy output channel.
- Sits between an HLS kernel's output stream and the LII router port. It is the sending end of the lane-0 unpack done at kernel inputs.
- Supports early flush of a partial word on s_tlast.

Parameters:
- DW, 64, kernel stream data width. PW mod DW must be 0.
- PW, 128, LII packing width. R = PW/DW, R >= 1.
- SRC_ID, 8'h00, value driven on lii_out_p0_src.
- DST_ID, 8'h00, value driven on lii_out_p0_dst.

Ports:
- aclk  in  1  clock; all state on rising edge.
- arstn  in  1  asynchronous active-low reset.
- s_tdata  in  DW  kernel stream data.
- s_tvalid  in  1  kernel beat valid.
- s_tready  out  1  packer accepts beat.
- s_tlast  in  1  flush: this beat closes the current word.
- lii_out_p0_tdata  out  PW  packed phy word.
- lii_out_p0_tvalid  out  1  phy word valid.
- lii_out_p0_tready  in  1  phy sink ready.
- lii_out_p0_src  out  8  constant SRC_ID.
- lii_out_p0_dst  out  8  constant DST_ID.
- words_sent  out  32  count of phy words handshaken.
- partial_flushes  out  16  count of words closed by s_tlast with fewer than R lanes.

Behaviour:
- State:
  - lane counter, 0..R-1.
  - accumulator, (R-1)*DW bits.
  - one-entry output register: out_data, out_valid.
  - two counters.
- Reset (async, arstn=0): lane=0, accumulator=0, out_valid=0, out_data=0, words_sent=0, partial_flushes=0. Outputs: lii_out_p0_tvalid=0, lii_out_p0_tdata=0. src/dst stay constant through reset.
- Lane order: beat k of a word occupies bits [k*DW +: DW]. Lane 0 is the first beat and sits in the LSBs.
- A completing beat is s_tvalid & (lane==R-1 | s_tlast).
- s_tready rules (combinational):
  - 1 for a non-completing beat.
  - For a completing beat: ~out_valid | lii_out_p0_tready.
  - s_tready may depend on s_tlast and lii_out_p0_tready, never on s_tdata.
- Non-completing accept: write lane `lane` of the accumulator; lane++.
- Completing accept:
  - out_data <= accumulator lanes 0..lane-1, current beat in lane `lane`, lanes above zero-filled.
  - out_valid <= 1; lane <= 0; accumulator <= 0.
- Output handshake (lii_out_p0_tvalid & lii_out_p0_tready): words_sent++ (wraps at 2^32). out_valid <= 0 unless a completing beat is accepted in the same cycle; the new word then loads, giving back-to-back output.
- Latency: word valid one cycle after its completing beat is accepted.
- Throughput: one phy word every R cycles with sustained input and tready=1. No bubble at word boundaries.
- partial_flushes++ when a completing accept has s_tlast=1 and lane<R-1. Saturates at 16'hFFFF.
- s_tlast on lane R-1 is a normal full word, not a partial flush.
- R==1: every beat completes; the block degenerates to a one-entry register slice.
- Backpressure: while out_valid=1 and tready=0, non-completing beats keep filling the accumulator. At most R-1 beats are buffered beyond the output register.
- out_data is held stable while tvalid=1 and tready=0 (AXI-stream rule). tvalid never deasserts without a handshake.
- Reset mid-word: accumulated beats and any pending output are discarded. No partial word is emitted after arstn rises.

Decomposition:
- Shared package lii_pkg:
  - LII_ID_W = 8.
  - function lii_ratio(PW, DW).
  - elaboration check that PW % DW == 0.
- One sub-module: lii_out_slice, the single-entry output register with valid/ready and hold-stable behaviour. Lane packing and counters stay in the top.

Test Plan:
- Reset, DW=64, PW=128, SRC_ID=8'h03, DST_ID=8'h07:
  - Beats 64'hA, 64'hB, tready=1 -> one word 128'h000..0B_000..0A, one cycle after beat 2.
  - src=03, dst=07, words_sent=1.
- Sustained input of 8 beats with tready=1 -> 4 words in consecutive pairs of cycles, no bubble, s_tready constantly 1, words_sent=4.
- Beat 64'h5 with s_tlast=1 at lane 0 -> word 128'h0..0_0000000000000005, partial_flushes=1. Next beat lands in lane 0.
- Hold tready=0 after the first word is formed; send beats C, D:
  - C accepted into the accumulator; D (completing) stalled with s_tready=0.
  - First word held stable.
  - Raise tready -> first word handshaken and word {D,C} loaded in the same cycle.
- Assert arstn=0 after one beat of a word -> tvalid=0 immediately, counters 0. After release, beats E, F -> word {F,E} with no stale lane data.
- PW=64, DW=64 (R=1) -> each beat yields one word next cycle. partial_flushes stays 0 even with s_tlast=1.
